// File: rtl/div_unit.sv
// Iterative RV32M divider: restoring division, one quotient bit per cycle.
// Computes DIV/DIVU/REM/REMU in XLEN+2 cycles; divide-by-zero and signed overflow finish in one.
module div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            wb_en
);

  localparam int CW = $clog2(XLEN) + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CALC  = 2'd1;
  localparam logic [1:0] FIXUP = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [1:0]      op_q, op_d;
  logic [4:0]      rdIn_q, rdIn_d;
  logic            dvdNeg_q, dvdNeg_d;
  logic            dvsNeg_q, dvsNeg_d;
  logic [XLEN-1:0] remAcc_q, remAcc_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvsMag_q, dvsMag_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [4:0]      rdOut_q, rdOut_d;

  logic            inSigned, inDvdNeg, inDvsNeg;
  logic [XLEN-1:0] inDvdMag, inDvsMag;
  logic [XLEN:0]   shifted, diff;
  logic            opSigned;
  logic [XLEN-1:0] quoFixed, remFixed;

  // Signed ops divide magnitudes; 0x80000000 negates to itself and is read as unsigned.
  always_comb begin
    inSigned = ~op[0];
    inDvdNeg = inSigned & dividend[XLEN-1];
    inDvsNeg = inSigned & divisor[XLEN-1];
    inDvdMag = inDvdNeg ? -dividend : dividend;
    inDvsMag = inDvsNeg ? -divisor  : divisor;
  end

  // Partial remainder is always below the divisor, so one extra bit holds the trial sign.
  always_comb begin
    shifted  = {remAcc_q, quo_q[XLEN-1]};
    diff     = shifted - {1'b0, dvsMag_q};
    opSigned = ~op_q[0];
    quoFixed = (opSigned && (dvdNeg_q ^ dvsNeg_q)) ? -quo_q : quo_q;
    remFixed = (opSigned && dvdNeg_q) ? -remAcc_q : remAcc_q;
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    op_d     = op_q;
    rdIn_d   = rdIn_q;
    dvdNeg_d = dvdNeg_q;
    dvsNeg_d = dvsNeg_q;
    remAcc_d = remAcc_q;
    quo_d    = quo_q;
    dvsMag_d = dvsMag_q;
    result_d = result_q;
    rdOut_d  = rdOut_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d     = op;
          rdIn_d   = rd_in;
          dvdNeg_d = inDvdNeg;
          dvsNeg_d = inDvsNeg;
          if (divisor == '0) begin
            result_d = op[1] ? dividend : ALL_ONES;
            rdOut_d  = rd_in;
            state_d  = DONE;
          end else if (inSigned && dividend == MIN_NEG && divisor == ALL_ONES) begin
            result_d = op[1] ? '0 : MIN_NEG;
            rdOut_d  = rd_in;
            state_d  = DONE;
          end else begin
            quo_d    = inDvdMag;
            remAcc_d = '0;
            dvsMag_d = inDvsMag;
            count_d  = CW'(XLEN);
            state_d  = CALC;
          end
        end
      end
      CALC: begin
        if (!diff[XLEN]) begin
          remAcc_d = diff[XLEN-1:0];
          quo_d    = {quo_q[XLEN-2:0], 1'b1};
        end else begin
          remAcc_d = shifted[XLEN-1:0];
          quo_d    = {quo_q[XLEN-2:0], 1'b0};
        end
        count_d = count_q - 1'b1;
        if (count_q == CW'(1)) state_d = FIXUP;
      end
      FIXUP: begin
        result_d = op_q[1] ? remFixed : quoFixed;
        rdOut_d  = rdIn_q;
        state_d  = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      op_q     <= '0;
      rdIn_q   <= '0;
      dvdNeg_q <= 1'b0;
      dvsNeg_q <= 1'b0;
      remAcc_q <= '0;
      quo_q    <= '0;
      dvsMag_q <= '0;
      result_q <= '0;
      rdOut_q  <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      op_q     <= op_d;
      rdIn_q   <= rdIn_d;
      dvdNeg_q <= dvdNeg_d;
      dvsNeg_q <= dvsNeg_d;
      remAcc_q <= remAcc_d;
      quo_q    <= quo_d;
      dvsMag_q <= dvsMag_d;
      result_q <= result_d;
      rdOut_q  <= rdOut_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign result = result_q;
  assign rd_out = rdOut_q;
  assign wb_en  = done & (rdOut_q != 5'd0);

endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit: latency, signed/unsigned results, special cases,
// start flooding while busy, mid-operation reset and the rd=0 write suppression.
module tb_div_unit;

  localparam int LIMIT = 60;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic [4:0]  rd_in = '0;
  logic        busy, done, wb_en;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int nCompared = 0;
  int nMismatched = 0;

  div_unit #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .dividend(dividend), .divisor(divisor), .rd_in(rd_in),
    .busy(busy), .done(done), .result(result), .rd_out(rd_out), .wb_en(wb_en)
  );

  always #5 clk = ~clk;

  // Issues one request, scrambles the inputs afterwards and waits (bounded) for done.
  task automatic runOp(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, output int lat, output logic [31:0] res,
                       output logic [4:0] rdo, output logic wb, output logic doneAfter);
    @(negedge clk);
    start = 1'b1; op = o; dividend = a; divisor = b; rd_in = rd;
    @(negedge clk);
    start = 1'b0; op = ~o; dividend = 32'hDEADBEEF; divisor = 32'h0; rd_in = 5'd31;
    lat = 1;
    while (done !== 1'b1 && lat < LIMIT) begin
      @(negedge clk);
      lat++;
    end
    res = result; rdo = rd_out; wb = wb_en;
    @(negedge clk);
    doneAfter = done;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    nCompared++; if (busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    nCompared++; if (done !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    nCompared++; if (wb_en !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_wb_en: got %b expected 0", wb_en); end
    nCompared++; if (result !== 32'h0) begin nMismatched++; $display("[TB] FAIL reset_result: got %h expected 0", result); end
    nCompared++; if (rd_out !== 5'd0) begin nMismatched++; $display("[TB] FAIL reset_rd_out: got %0d expected 0", rd_out); end
    reset = 1'b0;
  endtask

  task automatic test_signed;
    int lat; logic [31:0] res; logic [4:0] rdo; logic wb, da;
    runOp(2'b00, 32'hFFFFFFF9, 32'd2, 5'd5, lat, res, rdo, wb, da);
    nCompared++; if (lat !== 34) begin nMismatched++; $display("[TB] FAIL div_latency: got %0d expected 34", lat); end
    nCompared++; if (res !== 32'hFFFFFFFD) begin nMismatched++; $display("[TB] FAIL div_m7_2: got %h expected fffffffd", res); end
    nCompared++; if (rdo !== 5'd5) begin nMismatched++; $display("[TB] FAIL div_rd_out: got %0d expected 5", rdo); end
    nCompared++; if (wb !== 1'b1) begin nMismatched++; $display("[TB] FAIL div_wb_en: got %b expected 1", wb); end
    nCompared++; if (da !== 1'b0) begin nMismatched++; $display("[TB] FAIL div_done_width: got %b expected 0", da); end
    runOp(2'b10, 32'hFFFFFFF9, 32'd2, 5'd5, lat, res, rdo, wb, da);
    nCompared++; if (res !== 32'hFFFFFFFF) begin nMismatched++; $display("[TB] FAIL rem_m7_2: got %h expected ffffffff", res); end
    nCompared++; if (lat !== 34) begin nMismatched++; $display("[TB] FAIL rem_latency: got %0d expected 34", lat); end
    runOp(2'b10, 32'd7, 32'hFFFFFFFE, 5'd6, lat, res, rdo, wb, da);
    nCompared++; if (res !== 32'd1) begin nMismatched++; $display("[TB] FAIL rem_7_m2: got %h expected 1", res); end
    runOp(2'b00, 32'd7, 32'hFFFFFFFE, 5'd6, lat, res, rdo, wb, da);
    nCompared++; if (res !== 32'hFFFFFFFD) begin nMismatched++; $display("[TB] FAIL div_7_m2: got %h expected fffffffd", res); end
  endtask

  task automatic test_unsigned;
    int lat; logic [31:0] res; logic [4:0] rdo; logic wb, da;
    runOp(2'b01, 32'd100, 32'd7, 5'd1, lat, res, rdo, wb, da);
    nCompared++; if (res !== 32'd14) begin nMismatched++; $display("[TB] FAIL divu_100_7: got %h expected e", res); end
    runOp(2'b11, 32'd100, 32'd7, 5'd2, lat, res, rdo, wb, da);
    nCompared++; if (res !== 32'd2) begin nMismatched++; $display("[TB] FAIL remu_100_7: got %h expected 2", res); end
    nCompared++; if (rdo !== 5'd2) begin nMismatched++; $display("[TB] FAIL remu_rd_out: got %0d expected 2", rdo); end
    runOp(2'b01, 32'hFFFFFFFF, 32'd1, 5'd3, lat, res, rdo, wb, da);
    nCompared++; if (res !== 32'hFFFFFFFF) begin nMismatched++; $display("[TB] FAIL divu_max_1: got %h expected ffffffff", res); end
  endtask

  task automatic test_div_by_zero;
    int lat; logic [31:0] res; logic [4:0] rdo; logic wb, da;
    logic [31:0] expRes [4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1234, 32'h1234};
    for (int i = 0; i < 4; i++) begin
      runOp(2'(i), 32'h1234, 32'h0, 5'(10 + i), lat, res, rdo, wb, da);
      nCompared++; if (lat !== 1) begin nMismatched++; $display("[TB] FAIL dbz_latency op%0d: got %0d expected 1", i, lat); end
      nCompared++; if (res !== expRes[i]) begin nMismatched++; $display("[TB] FAIL dbz_result op%0d: got %h expected %h", i, res, expRes[i]); end
      nCompared++; if (rdo !== 5'(10 + i)) begin nMismatched++; $display("[TB] FAIL dbz_rd_out op%0d: got %0d expected %0d", i, rdo, 10 + i); end
    end
  endtask

  task automatic test_overflow;
    int lat; logic [31:0] res; logic [4:0] rdo; logic wb, da;
    int expLat [4] = '{1, 34, 1, 34};
    logic [31:0] expRes [4] = '{32'h80000000, 32'h0, 32'h0, 32'h80000000};
    for (int i = 0; i < 4; i++) begin
      runOp(2'(i), 32'h80000000, 32'hFFFFFFFF, 5'd20, lat, res, rdo, wb, da);
      nCompared++; if (lat !== expLat[i]) begin nMismatched++; $display("[TB] FAIL ovf_latency op%0d: got %0d expected %0d", i, lat, expLat[i]); end
      nCompared++; if (res !== expRes[i]) begin nMismatched++; $display("[TB] FAIL ovf_result op%0d: got %h expected %h", i, res, expRes[i]); end
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    @(negedge clk);
    start = 1'b1; op = 2'b01; dividend = 32'd100; divisor = 32'd7; rd_in = 5'd3;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      start = 1'b1; op = lat[1:0]; dividend = 32'(200 + lat); divisor = 32'(lat); rd_in = 5'd9;
    end while (done !== 1'b1 && lat < LIMIT);
    nCompared++; if (lat !== 34) begin nMismatched++; $display("[TB] FAIL flood_latency: got %0d expected 34", lat); end
    nCompared++; if (result !== 32'd14) begin nMismatched++; $display("[TB] FAIL flood_result: got %h expected e", result); end
    nCompared++; if (rd_out !== 5'd3) begin nMismatched++; $display("[TB] FAIL flood_rd_out: got %0d expected 3", rd_out); end
    @(negedge clk);
    nCompared++; if (busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL idle_gap_busy: got %b expected 0", busy); end
    start = 1'b1; op = 2'b01; dividend = 32'd9; divisor = 32'd3; rd_in = 5'd4;
    @(negedge clk);
    start = 1'b0;
    nCompared++; if (busy !== 1'b1) begin nMismatched++; $display("[TB] FAIL next_accept_busy: got %b expected 1", busy); end
    repeat (5) @(negedge clk);
    nCompared++; if (result !== 32'd14) begin nMismatched++; $display("[TB] FAIL result_hold: got %h expected e", result); end
    lat = 6;
    while (done !== 1'b1 && lat < LIMIT) begin
      @(negedge clk);
      lat++;
    end
    nCompared++; if (lat !== 34) begin nMismatched++; $display("[TB] FAIL second_latency: got %0d expected 34", lat); end
    nCompared++; if (result !== 32'd3) begin nMismatched++; $display("[TB] FAIL second_result: got %h expected 3", result); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_calc;
    int lat; logic [31:0] res; logic [4:0] rdo; logic wb, da;
    logic seenDone;
    @(negedge clk);
    start = 1'b1; op = 2'b01; dividend = 32'd1000; divisor = 32'd7; rd_in = 5'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    nCompared++; if (busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL abort_busy: got %b expected 0", busy); end
    nCompared++; if (done !== 1'b0) begin nMismatched++; $display("[TB] FAIL abort_done: got %b expected 0", done); end
    nCompared++; if (result !== 32'h0) begin nMismatched++; $display("[TB] FAIL abort_result: got %h expected 0", result); end
    nCompared++; if (rd_out !== 5'd0) begin nMismatched++; $display("[TB] FAIL abort_rd_out: got %0d expected 0", rd_out); end
    reset = 1'b0;
    seenDone = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) seenDone = 1'b1;
    end
    nCompared++; if (seenDone !== 1'b0) begin nMismatched++; $display("[TB] FAIL abort_no_done: got %b expected 0", seenDone); end
    runOp(2'b01, 32'd9, 32'd3, 5'd7, lat, res, rdo, wb, da);
    nCompared++; if (lat !== 34) begin nMismatched++; $display("[TB] FAIL fresh_latency: got %0d expected 34", lat); end
    nCompared++; if (res !== 32'd3) begin nMismatched++; $display("[TB] FAIL fresh_result: got %h expected 3", res); end
  endtask

  task automatic test_rd_zero;
    int lat; logic [31:0] res; logic [4:0] rdo; logic wb, da;
    runOp(2'b01, 32'd50, 32'd5, 5'd0, lat, res, rdo, wb, da);
    nCompared++; if (lat !== 34) begin nMismatched++; $display("[TB] FAIL rd0_done_latency: got %0d expected 34", lat); end
    nCompared++; if (wb !== 1'b0) begin nMismatched++; $display("[TB] FAIL rd0_wb_en: got %b expected 0", wb); end
    nCompared++; if (res !== 32'd10) begin nMismatched++; $display("[TB] FAIL rd0_result: got %h expected a", res); end
  endtask

  initial begin
    test_reset;
    test_signed;
    test_unsigned;
    test_div_by_zero;
    test_overflow;
    test_back_to_back;
    test_reset_mid_calc;
    test_rd_zero;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
